bus_control_unit: RTL and testbench

//  Timing-and-control sequencer that drives the 16-bit common bus block's control inputs (read, write, LD, INR, CLR, select, enable).

---
 rtl/bus_ctrl_pkg.sv | 72 +++++++
 rtl/bus_ctrl_decoder.sv | 115 +++++++++++
 rtl/bus_control_unit.sv | 76 +++++++
 tb/tb_bus_control_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared encodings for the bus control unit: bus select codes, strobe indices,
// opcode values, ALU operations, FSM states and the decoded control bundle.
package bus_ctrl_pkg;

   localparam int WIDTH      = 16;
   localparam int ADDR_WIDTH = 12;
   localparam int SC_WIDTH   = 3;

   // Bus source codes driven on select
   localparam logic [2:0] SEL_EXT = 3'd0;
   localparam logic [2:0] SEL_AR  = 3'd1;
   localparam logic [2:0] SEL_PC  = 3'd2;
   localparam logic [2:0] SEL_DR  = 3'd3;
   localparam logic [2:0] SEL_AC  = 3'd4;
   localparam logic [2:0] SEL_IR  = 3'd5;
   localparam logic [2:0] SEL_TR  = 3'd6;
   localparam logic [2:0] SEL_MEM = 3'd7;

   // LD strobe indices
   localparam int LD_AR = 0;
   localparam int LD_PC = 1;
   localparam int LD_DR = 2;
   localparam int LD_AC = 3;
   localparam int LD_IR = 4;
   localparam int LD_TR = 5;

   // INR / CLR strobe indices (shared map)
   localparam int RC_AR = 0;
   localparam int RC_PC = 1;
   localparam int RC_DR = 2;
   localparam int RC_AC = 3;
   localparam int RC_TR = 4;

   // Opcode field D = IR[14:12]
   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STA = 3'd3;
   localparam logic [2:0] OP_BUN = 3'd4;
   localparam logic [2:0] OP_BSA = 3'd5;
   localparam logic [2:0] OP_ISZ = 3'd6;
   localparam logic [2:0] OP_REG = 3'd7;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_AND  = 2'b01;
   localparam logic [1:0] ALU_ADD  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // sc_clr and hlt are internal sequencing requests back to the top level
   typedef struct packed {
      logic       read;
      logic       write;
      logic [5:0] ld;
      logic [4:0] inr;
      logic [4:0] clr;
      logic [2:0] sel;
      logic       enable;
      logic [1:0] alu_op;
      logic       sc_clr;
      logic       hlt;
   } ctrl_t;

   function automatic logic [2:0] opcode_d(input logic [WIDTH-1:0] ir);
      return ir[ADDR_WIDTH+2:ADDR_WIDTH];
   endfunction

endpackage

// File: rtl/bus_ctrl_decoder.sv
// Combinational control decode: maps (state, T-index, IR, bus value) onto the
// common bus control strobes. Everything is forced low outside RUN or in reset.
module bus_ctrl_decoder
   import bus_ctrl_pkg::*;
(
   input  state_t              state,
   input  logic                reset_n,
   input  logic [SC_WIDTH-1:0] sc,
   input  logic [WIDTH-1:0]    ir,
   input  logic [WIDTH-1:0]    bus_data,
   output ctrl_t               ctrl
);

   logic [2:0] d;
   logic       ind;
   logic       unused_ir;

   assign d         = opcode_d(ir);
   assign ind       = ir[WIDTH-1];
   assign unused_ir = ^{ir[10:6], ir[4:1]};

   always_comb begin
      ctrl = '0;
      if (state == ST_RUN && reset_n) begin
         ctrl.enable = 1'b1;
         case (sc)
            3'd0: begin
               ctrl.sel       = SEL_PC;
               ctrl.ld[LD_AR] = 1'b1;
            end
            3'd1: begin
               ctrl.sel        = SEL_MEM;
               ctrl.read       = 1'b1;
               ctrl.ld[LD_IR]  = 1'b1;
               ctrl.inr[RC_PC] = 1'b1;
            end
            3'd2: begin
               ctrl.sel       = SEL_IR;
               ctrl.ld[LD_AR] = 1'b1;
            end
            3'd3: begin
               if (d == OP_REG) begin
                  // Register-reference only when direct; I=1 with D=7 is a no-op
                  if (!ind) begin
                     if (ir[11])
                        ctrl.clr[RC_AC] = 1'b1;
                     else if (ir[5])
                        ctrl.inr[RC_AC] = 1'b1;
                     ctrl.hlt = ir[0];
                  end
                  ctrl.sc_clr = 1'b1;
               end else if (ind) begin
                  ctrl.sel       = SEL_MEM;
                  ctrl.read      = 1'b1;
                  ctrl.ld[LD_AR] = 1'b1;
               end
            end
            3'd4: begin
               case (d)
                  OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                     ctrl.sel       = SEL_MEM;
                     ctrl.read      = 1'b1;
                     ctrl.ld[LD_DR] = 1'b1;
                  end
                  OP_STA: begin
                     ctrl.sel    = SEL_AC;
                     ctrl.write  = 1'b1;
                     ctrl.sc_clr = 1'b1;
                  end
                  OP_BUN: begin
                     ctrl.sel       = SEL_AR;
                     ctrl.ld[LD_PC] = 1'b1;
                     ctrl.sc_clr    = 1'b1;
                  end
                  OP_BSA: begin
                     ctrl.sel        = SEL_PC;
                     ctrl.write      = 1'b1;
                     ctrl.inr[RC_AR] = 1'b1;
                  end
                  default: ctrl.sc_clr = 1'b1;
               endcase
            end
            3'd5: begin
               case (d)
                  OP_AND, OP_ADD, OP_LDA: begin
                     ctrl.sel       = SEL_DR;
                     ctrl.ld[LD_AC] = 1'b1;
                     ctrl.sc_clr    = 1'b1;
                     ctrl.alu_op    = (d == OP_AND) ? ALU_AND :
                                      (d == OP_ADD) ? ALU_ADD : ALU_PASS;
                  end
                  OP_BSA: begin
                     ctrl.sel       = SEL_AR;
                     ctrl.ld[LD_PC] = 1'b1;
                     ctrl.sc_clr    = 1'b1;
                  end
                  OP_ISZ: ctrl.inr[RC_DR] = 1'b1;
                  default: ctrl.sc_clr = 1'b1;
               endcase
            end
            3'd6: begin
               // Bus carries DR+1 here, so a zero bus means skip the next word
               if (d == OP_ISZ) begin
                  ctrl.sel        = SEL_DR;
                  ctrl.write      = 1'b1;
                  ctrl.inr[RC_PC] = (bus_data == '0);
               end
               ctrl.sc_clr = 1'b1;
            end
            default: ctrl.sc_clr = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/bus_control_unit.sv
// Timing-and-control sequencer for the common bus: holds run state, the T-state
// sequence counter and the instruction register snooped off the bus at T1.
module bus_control_unit
   import bus_ctrl_pkg::*;
(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                start,
   input  logic [WIDTH-1:0]    bus_data,
   output logic                read,
   output logic                write,
   output logic [5:0]          LD,
   output logic [4:0]          INR,
   output logic [4:0]          CLR,
   output logic [2:0]          select,
   output logic                enable,
   output logic [1:0]          alu_op,
   output logic                halted,
   output logic [SC_WIDTH-1:0] sc
);

   state_t              state_q;
   logic [SC_WIDTH-1:0] sc_q;
   logic [SC_WIDTH-1:0] sc_d;
   logic [WIDTH-1:0]    ir_q;
   ctrl_t               ctrl;

   bus_ctrl_decoder u_decoder (
      .state    (state_q),
      .reset_n  (reset_n),
      .sc       (sc_q),
      .ir       (ir_q),
      .bus_data (bus_data),
      .ctrl     (ctrl)
   );

   assign sc_d = ctrl.sc_clr ? '0 : sc_q + SC_WIDTH'(1);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         sc_q    <= '0;
         ir_q    <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               sc_q <= sc_d;
               if (sc_q == SC_WIDTH'(1))
                  ir_q <= bus_data;
               if (ctrl.hlt)
                  state_q <= ST_HALT;
            end
            ST_IDLE, ST_HALT: begin
               // PC lives in the register file, so resuming from HALT just restarts at T0
               if (start) begin
                  state_q <= ST_RUN;
                  sc_q    <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign read   = ctrl.read;
   assign write  = ctrl.write;
   assign LD     = ctrl.ld;
   assign INR    = ctrl.inr;
   assign CLR    = ctrl.clr;
   assign select = ctrl.sel;
   assign enable = ctrl.enable;
   assign alu_op = ctrl.alu_op;
   assign halted = (state_q == ST_HALT);
   assign sc     = ctrl.enable ? sc_q : '0;

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed bench for bus_control_unit: the driver applies one cycle of inputs and
// queues the hand-computed output vector; a negedge monitor pops and compares.
module tb_bus_control_unit;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [15:0] bus_data;
   logic        read;
   logic        write;
   logic [5:0]  LD;
   logic [4:0]  INR;
   logic [4:0]  CLR;
   logic [2:0]  select;
   logic        enable;
   logic [1:0]  alu_op;
   logic        halted;
   logic [2:0]  sc;

   int n_checks = 0;
   int n_fails  = 0;

   logic [27:0] exp_q[$];
   string       name_q[$];

   bus_control_unit dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .bus_data (bus_data),
      .read     (read),
      .write    (write),
      .LD       (LD),
      .INR      (INR),
      .CLR      (CLR),
      .select   (select),
      .enable   (enable),
      .alu_op   (alu_op),
      .halted   (halted),
      .sc       (sc)
   );

   // clock / reset
   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required end of stimulus");
      $fatal(1, "watchdog expired");
   end

   // {read, write, LD, INR, CLR, select, enable, alu_op, halted, sc}
   function automatic logic [27:0] ev(input logic rd, input logic wr, input logic [5:0] ld,
                                      input logic [4:0] inr, input logic [4:0] clr,
                                      input logic [2:0] sel, input logic en,
                                      input logic [1:0] alu, input logic hl,
                                      input logic [2:0] s);
      return {rd, wr, ld, inr, clr, sel, en, alu, hl, s};
   endfunction

   function automatic logic [27:0] t3_none();
      return ev(1'b0, 1'b0, 6'b0, 5'b0, 5'b0, 3'd0, 1'b1, 2'b00, 1'b0, 3'd3);
   endfunction

   function automatic logic [27:0] t4_read_dr();
      return ev(1'b1, 1'b0, 6'b000100, 5'b0, 5'b0, 3'd7, 1'b1, 2'b00, 1'b0, 3'd4);
   endfunction

   // driver tasks
   task automatic step(input logic rst, input logic st, input logic [15:0] bus,
                       input logic [27:0] exp, input string nm);
      reset_n  = rst;
      start    = st;
      bus_data = bus;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [15:0] ins);
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b000001, 5'b0, 5'b0, 3'd2, 1'b1, 2'b00, 1'b0, 3'd0), "T0");
      step(1'b1, 1'b0, ins,      ev(1'b1, 1'b0, 6'b010000, 5'b00010, 5'b0, 3'd7, 1'b1, 2'b00, 1'b0, 3'd1), "T1");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b000001, 5'b0, 5'b0, 3'd5, 1'b1, 2'b00, 1'b0, 3'd2), "T2");
   endtask

   // scoreboard monitor
   always @(negedge clock) begin
      logic [27:0] act;
      logic [27:0] exp;
      string       nm;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {read, write, LD, INR, CLR, select, enable, alu_op, halted, sc};
         n_checks++;
         if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %07h required %07h (rd wr LD INR CLR sel en alu hlt sc)", nm, act, exp);
         end
         if (read && write) begin
            n_checks++;
            n_fails++;
            $display("FAIL %s rd_wr_excl: got read=1 write=1 required not both", nm);
         end
      end
   end

   localparam logic [27:0] ZERO = 28'h0;

   initial begin
      logic [27:0] halt_v;
      halt_v   = ev(1'b0, 1'b0, 6'b0, 5'b0, 5'b0, 3'd0, 1'b0, 2'b00, 1'b1, 3'd0);
      reset_n  = 1'b0;
      start    = 1'b0;
      bus_data = 16'h0000;
      @(posedge clock);
      #1;

      // reset and start
      step(1'b0, 1'b0, 16'h0000, ZERO, "rst0");
      step(1'b0, 1'b1, 16'h0000, ZERO, "rst_dominates_start");
      step(1'b1, 1'b0, 16'h0000, ZERO, "idle");
      step(1'b1, 1'b1, 16'h0000, ZERO, "idle_start");

      // LDA direct
      fetch(16'h2005);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "lda_t3");
      step(1'b1, 1'b0, 16'h1234, t4_read_dr(), "lda_t4");
      step(1'b1, 1'b0, 16'h1234, ev(1'b0, 1'b0, 6'b001000, 5'b0, 5'b0, 3'd3, 1'b1, 2'b00, 1'b0, 3'd5), "lda_t5");

      // ADD indirect
      fetch(16'h9010);
      step(1'b1, 1'b0, 16'h0055, ev(1'b1, 1'b0, 6'b000001, 5'b0, 5'b0, 3'd7, 1'b1, 2'b00, 1'b0, 3'd3), "add_ind_t3");
      step(1'b1, 1'b0, 16'h0042, t4_read_dr(), "add_t4");
      step(1'b1, 1'b0, 16'h0042, ev(1'b0, 1'b0, 6'b001000, 5'b0, 5'b0, 3'd3, 1'b1, 2'b10, 1'b0, 3'd5), "add_t5");

      // AND direct, start pulsed mid-instruction
      fetch(16'h0007);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "and_t3");
      step(1'b1, 1'b1, 16'h00F0, t4_read_dr(), "and_t4_start_ignored");
      step(1'b1, 1'b0, 16'h00F0, ev(1'b0, 1'b0, 6'b001000, 5'b0, 5'b0, 3'd3, 1'b1, 2'b01, 1'b0, 3'd5), "and_t5");

      // STA, then STA with reset during T4
      fetch(16'h3020);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "sta_t3");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b1, 6'b0, 5'b0, 5'b0, 3'd4, 1'b1, 2'b00, 1'b0, 3'd4), "sta_t4");
      fetch(16'h3020);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "sta2_t3");
      step(1'b0, 1'b0, 16'h0000, ZERO, "sta2_t4_reset");
      step(1'b1, 1'b0, 16'h0000, ZERO, "after_reset_idle");
      step(1'b1, 1'b1, 16'h0000, ZERO, "restart");

      // BUN
      fetch(16'h4123);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "bun_t3");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b000010, 5'b0, 5'b0, 3'd1, 1'b1, 2'b00, 1'b0, 3'd4), "bun_t4");

      // BSA
      fetch(16'h5040);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "bsa_t3");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b1, 6'b0, 5'b00001, 5'b0, 3'd2, 1'b1, 2'b00, 1'b0, 3'd4), "bsa_t4");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b000010, 5'b0, 5'b0, 3'd1, 1'b1, 2'b00, 1'b0, 3'd5), "bsa_t5");

      // ISZ, result zero then nonzero
      fetch(16'h6030);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "isz_t3");
      step(1'b1, 1'b0, 16'hFFFF, t4_read_dr(), "isz_t4");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b0, 5'b00100, 5'b0, 3'd0, 1'b1, 2'b00, 1'b0, 3'd5), "isz_t5");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b1, 6'b0, 5'b00010, 5'b0, 3'd3, 1'b1, 2'b00, 1'b0, 3'd6), "isz_t6_zero");
      fetch(16'h6030);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "isz2_t3");
      step(1'b1, 1'b0, 16'h0004, t4_read_dr(), "isz2_t4");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b0, 5'b00100, 5'b0, 3'd0, 1'b1, 2'b00, 1'b0, 3'd5), "isz2_t5");
      step(1'b1, 1'b0, 16'h0005, ev(1'b0, 1'b1, 6'b0, 5'b00000, 5'b0, 3'd3, 1'b1, 2'b00, 1'b0, 3'd6), "isz2_t6_nonzero");

      // register-reference variants
      fetch(16'h7020);
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b0, 5'b01000, 5'b0, 3'd0, 1'b1, 2'b00, 1'b0, 3'd3), "inc_t3");
      fetch(16'h7820);
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b0, 5'b0, 5'b01000, 3'd0, 1'b1, 2'b00, 1'b0, 3'd3), "cla_over_inc_t3");
      fetch(16'hF001);
      step(1'b1, 1'b0, 16'h0000, t3_none(), "d7_ind_noop_t3");

      // CLA + HLT, hold in HALT, resume
      fetch(16'h7801);
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b0, 5'b0, 5'b01000, 3'd0, 1'b1, 2'b00, 1'b0, 3'd3), "cla_hlt_t3");
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 16'h0000, halt_v, "halted_hold");
      step(1'b1, 1'b1, 16'h0000, halt_v, "halt_start");
      step(1'b1, 1'b0, 16'h0000, ev(1'b0, 1'b0, 6'b000001, 5'b0, 5'b0, 3'd2, 1'b1, 2'b00, 1'b0, 3'd0), "resume_t0");

      @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
